// File: rtl/axi_pkg.sv
// Shared AXI definitions: response encoding used by the full AXI4 and
// AXI4-Lite interfaces and by the protocol converters built on them.
package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_intf.sv
// AXI4 (AXI_BUS) and AXI4-Lite (AXI_LITE) interface bundles.
//   AXI_BUS  : AW/W/B/AR/R channels with id, len, size, burst, lock, cache,
//              prot, qos, region, atop and user sidebands.
//              Modports Master and Slave.
//   AXI_LITE : AW/W/B/AR/R channels with addr, prot, data, strb, resp only.
//              Modports Master and Slave.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 8,
  parameter int unsigned AXI_USER_WIDTH = 8
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  axi_pkg::resp_t            b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  axi_pkg::resp_t            r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]                aw_prot;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_valid;
  logic                      w_ready;

  axi_pkg::resp_t            b_resp;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]                ar_prot;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  axi_pkg::resp_t            r_resp;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input  b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/axi_to_axi_lite_adapter.sv
// AXI4 slave port to AXI4-Lite master port converter.
// One outstanding transaction per direction; read and write paths are
// independent. Single-beat transfers (len==0) are forwarded to the Lite
// side; bursts are absorbed locally and answered with SLVERR.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   slave   : AXI_BUS.Slave  (full AXI4, AW/W/B/AR/R)
//   master  : AXI_LITE.Master (AXI4-Lite, AW/W/B/AR/R)
module axi_to_axi_lite_adapter
  import axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 8,
  parameter int unsigned AXI_USER_WIDTH = 8
) (
  input  logic    clk_i,
  input  logic    rst_i,
  AXI_BUS.Slave   slave,
  AXI_LITE.Master master
);

  typedef enum logic [2:0] {
    W_IDLE, W_ADDR_DATA, W_BRESP_WAIT, W_SEND_B, W_DRAIN
  } w_state_e;

  typedef enum logic [2:0] {
    R_IDLE, R_ADDR, R_DATA_WAIT, R_SEND, R_ERR
  } r_state_e;

  // ---------------- write path ----------------
  w_state_e                  w_state, w_state_nxt;
  logic [AXI_ID_WIDTH-1:0]   w_id;
  resp_t                     w_resp;
  logic                      aw_done, w_done;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [2:0]                w_prot;

  logic s_aw_ready, s_w_ready, s_b_valid;
  logic m_aw_valid, m_w_valid, m_b_ready;
  logic aw_hs_s, aw_hs_m, w_hs_m;

  always_comb begin
    w_state_nxt = w_state;
    s_aw_ready  = 1'b0;
    s_w_ready   = 1'b0;
    s_b_valid   = 1'b0;
    m_aw_valid  = 1'b0;
    m_w_valid   = 1'b0;
    m_b_ready   = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_aw_ready = 1'b1;
        if (slave.aw_valid)
          w_state_nxt = (slave.aw_len == 8'd0) ? W_ADDR_DATA : W_DRAIN;
      end
      W_ADDR_DATA: begin
        // W is a straight passthrough until its beat has been taken once
        m_aw_valid = ~aw_done;
        m_w_valid  = slave.w_valid & ~w_done;
        s_w_ready  = master.w_ready & ~w_done;
        if ((aw_done | (m_aw_valid & master.aw_ready)) &&
            (w_done  | (m_w_valid  & master.w_ready)))
          w_state_nxt = W_BRESP_WAIT;
      end
      W_BRESP_WAIT: begin
        m_b_ready = 1'b1;
        if (master.b_valid) w_state_nxt = W_SEND_B;
      end
      W_SEND_B: begin
        s_b_valid = 1'b1;
        if (slave.b_ready) w_state_nxt = W_IDLE;
      end
      W_DRAIN: begin
        s_w_ready = 1'b1;
        if (slave.w_valid && slave.w_last) w_state_nxt = W_SEND_B;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs_s = (w_state == W_IDLE) & slave.aw_valid;
  assign aw_hs_m = m_aw_valid & master.aw_ready;
  assign w_hs_m  = m_w_valid & master.w_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_resp  <= RESP_OKAY;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs_s) begin
        w_id    <= slave.aw_id;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs_m) aw_done <= 1'b1;
      if (w_hs_m)  w_done  <= 1'b1;
      if (w_state == W_BRESP_WAIT && master.b_valid) w_resp <= master.b_resp;
      if (w_state == W_DRAIN && slave.w_valid && slave.w_last) w_resp <= RESP_SLVERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_hs_s) begin
      w_addr <= slave.aw_addr;
      w_prot <= slave.aw_prot;
    end
  end

  // Readies are held low for the whole reset interval, not just after it
  assign slave.aw_ready  = s_aw_ready & ~rst_i;
  assign slave.w_ready   = s_w_ready;
  assign slave.b_valid   = s_b_valid;
  assign slave.b_id      = w_id;
  assign slave.b_resp    = w_resp;
  assign slave.b_user    = '0;

  assign master.aw_valid = m_aw_valid;
  assign master.aw_addr  = w_addr;
  assign master.aw_prot  = w_prot;
  assign master.w_valid  = m_w_valid;
  assign master.w_data   = slave.w_data;
  assign master.w_strb   = slave.w_strb;
  assign master.b_ready  = m_b_ready;

  // ---------------- read path ----------------
  r_state_e                  r_state, r_state_nxt;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  resp_t                     r_resp;
  logic [7:0]                r_cnt;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [2:0]                r_prot;

  logic s_ar_ready, s_r_valid, s_r_last;
  logic m_ar_valid, m_r_ready;
  logic ar_hs_s, r_hs_m;

  always_comb begin
    r_state_nxt = r_state;
    s_ar_ready  = 1'b0;
    s_r_valid   = 1'b0;
    s_r_last    = 1'b0;
    m_ar_valid  = 1'b0;
    m_r_ready   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_ar_ready = 1'b1;
        if (slave.ar_valid)
          r_state_nxt = (slave.ar_len == 8'd0) ? R_ADDR : R_ERR;
      end
      R_ADDR: begin
        m_ar_valid = 1'b1;
        if (master.ar_ready) r_state_nxt = R_DATA_WAIT;
      end
      R_DATA_WAIT: begin
        m_r_ready = 1'b1;
        if (master.r_valid) r_state_nxt = R_SEND;
      end
      R_SEND: begin
        s_r_valid = 1'b1;
        s_r_last  = 1'b1;
        if (slave.r_ready) r_state_nxt = R_IDLE;
      end
      R_ERR: begin
        // r_cnt counts remaining beats after the current one
        s_r_valid = 1'b1;
        s_r_last  = (r_cnt == 8'd0);
        if (slave.r_ready && r_cnt == 8'd0) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_hs_s = (r_state == R_IDLE) & slave.ar_valid;
  assign r_hs_m  = (r_state == R_DATA_WAIT) & master.r_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_resp  <= RESP_OKAY;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs_s) begin
        r_id   <= slave.ar_id;
        r_cnt  <= slave.ar_len;
        r_resp <= (slave.ar_len == 8'd0) ? RESP_OKAY : RESP_SLVERR;
      end
      if (r_hs_m) r_resp <= master.r_resp;
      if (r_state == R_ERR && slave.r_ready && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
    end
  end

  // Error beats carry zero data, so the data register is cleared on accept
  always_ff @(posedge clk_i) begin
    if (ar_hs_s) begin
      r_addr <= slave.ar_addr;
      r_prot <= slave.ar_prot;
      r_data <= '0;
    end
    if (r_hs_m) r_data <= master.r_data;
  end

  assign slave.ar_ready  = s_ar_ready & ~rst_i;
  assign slave.r_valid   = s_r_valid;
  assign slave.r_last    = s_r_last;
  assign slave.r_id      = r_id;
  assign slave.r_data    = r_data;
  assign slave.r_resp    = r_resp;
  assign slave.r_user    = '0;

  assign master.ar_valid = m_ar_valid;
  assign master.ar_addr  = r_addr;
  assign master.ar_prot  = r_prot;
  assign master.r_ready  = m_r_ready;

  // Sidebands with no AXI-Lite counterpart
  logic unused_fields;
  assign unused_fields = ^{slave.aw_size, slave.aw_burst, slave.aw_lock, slave.aw_cache,
                           slave.aw_qos, slave.aw_region, slave.aw_atop, slave.aw_user,
                           slave.w_user, slave.ar_size, slave.ar_burst, slave.ar_lock,
                           slave.ar_cache, slave.ar_qos, slave.ar_region, slave.ar_user};

endmodule

// File: tb/tb_axi_to_axi_lite_adapter.sv
// Directed testbench for axi_to_axi_lite_adapter: the bench plays the AXI4
// master on the slave port and the AXI-Lite peripheral on the master port.
module tb_axi_to_axi_lite_adapter;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8),
            .AXI_USER_WIDTH(8)) sbus ();
  AXI_LITE #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) mbus ();

  axi_to_axi_lite_adapter #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8), .AXI_USER_WIDTH(8)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .slave  (sbus),
    .master (mbus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_bus();
    sbus.aw_id = '0; sbus.aw_addr = '0; sbus.aw_len = '0; sbus.aw_size = 3'd2;
    sbus.aw_burst = 2'b01; sbus.aw_lock = 1'b0; sbus.aw_cache = '0; sbus.aw_prot = '0;
    sbus.aw_qos = '0; sbus.aw_region = '0; sbus.aw_atop = '0; sbus.aw_user = '0;
    sbus.aw_valid = 1'b0;
    sbus.w_data = '0; sbus.w_strb = '0; sbus.w_last = 1'b0; sbus.w_user = '0;
    sbus.w_valid = 1'b0; sbus.b_ready = 1'b0;
    sbus.ar_id = '0; sbus.ar_addr = '0; sbus.ar_len = '0; sbus.ar_size = 3'd2;
    sbus.ar_burst = 2'b01; sbus.ar_lock = 1'b0; sbus.ar_cache = '0; sbus.ar_prot = '0;
    sbus.ar_qos = '0; sbus.ar_region = '0; sbus.ar_user = '0; sbus.ar_valid = 1'b0;
    sbus.r_ready = 1'b0;
    mbus.aw_ready = 1'b0; mbus.w_ready = 1'b0;
    mbus.b_resp = '0; mbus.b_valid = 1'b0;
    mbus.ar_ready = 1'b0;
    mbus.r_data = '0; mbus.r_resp = '0; mbus.r_valid = 1'b0;
  endtask

  // Single-beat write. aw_wait>0 presents W a cycle ahead of AW and holds
  // the Lite aw_ready low; b_wait delays the slave-side b_ready.
  task automatic write_single(input logic [7:0] id, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input logic [1:0] lresp, input int aw_wait, input int b_wait);
    sbus.w_data = data; sbus.w_strb = strb; sbus.w_last = 1'b1;
    mbus.w_ready = 1'b1;
    mbus.aw_ready = (aw_wait == 0);
    if (aw_wait > 0) begin
      sbus.w_valid = 1'b1;
      #1 chk("wr_w_blocked_idle", 64'(sbus.w_ready), 64'd0);
      chk("wr_m_w_idle", 64'(mbus.w_valid), 64'd0);
      step();
    end
    sbus.aw_id = id; sbus.aw_addr = addr; sbus.aw_len = 8'd0; sbus.aw_valid = 1'b1;
    sbus.w_valid = 1'b1;
    #1 chk("wr_aw_ready", 64'(sbus.aw_ready), 64'd1);
    chk("wr_m_aw_early", 64'(mbus.aw_valid), 64'd0);
    step();
    sbus.aw_valid = 1'b0;
    #1 chk("wr_m_aw_valid", 64'(mbus.aw_valid), 64'd1);
    chk("wr_m_aw_addr", 64'(mbus.aw_addr), 64'(addr));
    chk("wr_m_w_valid", 64'(mbus.w_valid), 64'd1);
    chk("wr_m_w_data", 64'(mbus.w_data), 64'(data));
    chk("wr_m_w_strb", 64'(mbus.w_strb), 64'(strb));
    chk("wr_s_w_ready", 64'(sbus.w_ready), 64'd1);
    step();
    sbus.w_valid = 1'b0;
    for (int i = 0; i < aw_wait; i++) begin
      #1 chk("wr_aw_hold", 64'(mbus.aw_valid), 64'd1);
      chk("wr_aw_addr_hold", 64'(mbus.aw_addr), 64'(addr));
      chk("wr_w_once", 64'(mbus.w_valid), 64'd0);
      if (i == aw_wait - 1) mbus.aw_ready = 1'b1;
      step();
    end
    mbus.aw_ready = 1'b0; mbus.w_ready = 1'b0;
    #1 chk("wr_b_ready", 64'(mbus.b_ready), 64'd1);
    chk("wr_aw_dropped", 64'(mbus.aw_valid), 64'd0);
    chk("wr_s_b_early", 64'(sbus.b_valid), 64'd0);
    mbus.b_valid = 1'b1; mbus.b_resp = lresp;
    step();
    mbus.b_valid = 1'b0; mbus.b_resp = ~lresp;
    for (int i = 0; i <= b_wait; i++) begin
      #1 chk("wr_b_valid", 64'(sbus.b_valid), 64'd1);
      chk("wr_b_id", 64'(sbus.b_id), 64'(id));
      chk("wr_b_resp", 64'(sbus.b_resp), 64'(lresp));
      chk("wr_b_user", 64'(sbus.b_user), 64'd0);
      chk("wr_m_b_ready_off", 64'(mbus.b_ready), 64'd0);
      if (i == b_wait) sbus.b_ready = 1'b1;
      step();
    end
    sbus.b_ready = 1'b0;
    #1 chk("wr_b_once", 64'(sbus.b_valid), 64'd0);
    chk("wr_back_idle", 64'(sbus.aw_ready), 64'd1);
  endtask

  // Single-beat read with Lite data/resp supplied by the bench.
  task automatic read_single(input logic [7:0] id, input logic [31:0] addr,
                             input logic [31:0] ldata, input logic [1:0] lresp,
                             input int r_wait);
    sbus.ar_id = id; sbus.ar_addr = addr; sbus.ar_len = 8'd0; sbus.ar_valid = 1'b1;
    mbus.ar_ready = 1'b0;
    #1 chk("rd_ar_ready", 64'(sbus.ar_ready), 64'd1);
    chk("rd_m_ar_early", 64'(mbus.ar_valid), 64'd0);
    step();
    sbus.ar_valid = 1'b0;
    #1 chk("rd_m_ar_valid", 64'(mbus.ar_valid), 64'd1);
    chk("rd_m_ar_addr", 64'(mbus.ar_addr), 64'(addr));
    chk("rd_m_r_ready_early", 64'(mbus.r_ready), 64'd0);
    mbus.ar_ready = 1'b1;
    step();
    mbus.ar_ready = 1'b0;
    #1 chk("rd_m_ar_dropped", 64'(mbus.ar_valid), 64'd0);
    chk("rd_m_r_ready", 64'(mbus.r_ready), 64'd1);
    chk("rd_s_r_early", 64'(sbus.r_valid), 64'd0);
    mbus.r_valid = 1'b1; mbus.r_data = ldata; mbus.r_resp = lresp;
    step();
    mbus.r_valid = 1'b0; mbus.r_data = ~ldata; mbus.r_resp = ~lresp;
    for (int i = 0; i <= r_wait; i++) begin
      #1 chk("rd_r_valid", 64'(sbus.r_valid), 64'd1);
      chk("rd_r_id", 64'(sbus.r_id), 64'(id));
      chk("rd_r_data", 64'(sbus.r_data), 64'(ldata));
      chk("rd_r_resp", 64'(sbus.r_resp), 64'(lresp));
      chk("rd_r_last", 64'(sbus.r_last), 64'd1);
      chk("rd_r_user", 64'(sbus.r_user), 64'd0);
      if (i == r_wait) sbus.r_ready = 1'b1;
      step();
    end
    sbus.r_ready = 1'b0;
    #1 chk("rd_r_once", 64'(sbus.r_valid), 64'd0);
    chk("rd_back_idle", 64'(sbus.ar_ready), 64'd1);
  endtask

  initial begin
    init_bus();
    rst = 1'b1;
    step(); step(); step();

    // reset state
    chk("rst_s_aw_ready", 64'(sbus.aw_ready), 64'd0);
    chk("rst_s_ar_ready", 64'(sbus.ar_ready), 64'd0);
    chk("rst_s_w_ready", 64'(sbus.w_ready), 64'd0);
    chk("rst_s_b_valid", 64'(sbus.b_valid), 64'd0);
    chk("rst_s_r_valid", 64'(sbus.r_valid), 64'd0);
    chk("rst_m_aw_valid", 64'(mbus.aw_valid), 64'd0);
    chk("rst_m_w_valid", 64'(mbus.w_valid), 64'd0);
    chk("rst_m_ar_valid", 64'(mbus.ar_valid), 64'd0);
    chk("rst_m_b_ready", 64'(mbus.b_ready), 64'd0);
    chk("rst_m_r_ready", 64'(mbus.r_ready), 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_aw_ready", 64'(sbus.aw_ready), 64'd1);
    chk("post_rst_ar_ready", 64'(sbus.ar_ready), 64'd1);
    chk("post_rst_b_id", 64'(sbus.b_id), 64'd0);
    chk("post_rst_r_id", 64'(sbus.r_id), 64'd0);
    step();

    // single write / read, then error responses from the Lite side
    write_single(8'h5A, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, RESP_OKAY, 0, 0);
    read_single(8'h33, 32'h0000_2004, 32'h0000_0000, RESP_OKAY, 0);
    write_single(8'hA1, 32'h0000_1100, 32'h1234_5678, 4'h3, RESP_SLVERR, 0, 0);
    read_single(8'hB2, 32'h0000_2200, 32'hCAFE_F00D, RESP_DECERR, 0);

    // write burst len=3: four beats drained, nothing forwarded
    sbus.aw_id = 8'hC3; sbus.aw_addr = 32'h0000_3000; sbus.aw_len = 8'd3; sbus.aw_valid = 1'b1;
    step();
    sbus.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sbus.w_valid = 1'b1; sbus.w_data = 32'(i); sbus.w_strb = 4'hF; sbus.w_last = (i == 3);
      #1 chk("wb_s_w_ready", 64'(sbus.w_ready), 64'd1);
      chk("wb_m_aw_valid", 64'(mbus.aw_valid), 64'd0);
      chk("wb_m_w_valid", 64'(mbus.w_valid), 64'd0);
      chk("wb_s_b_early", 64'(sbus.b_valid), 64'd0);
      step();
    end
    sbus.w_valid = 1'b0; sbus.w_last = 1'b0;
    #1 chk("wb_b_valid", 64'(sbus.b_valid), 64'd1);
    chk("wb_b_resp", 64'(sbus.b_resp), 64'(RESP_SLVERR));
    chk("wb_b_id", 64'(sbus.b_id), 64'hC3);
    sbus.b_ready = 1'b1;
    step();
    sbus.b_ready = 1'b0;
    #1 chk("wb_b_once", 64'(sbus.b_valid), 64'd0);

    // read burst len=1: two SLVERR beats, last only on the second
    sbus.ar_id = 8'hD4; sbus.ar_addr = 32'h0000_4000; sbus.ar_len = 8'd1; sbus.ar_valid = 1'b1;
    step();
    sbus.ar_valid = 1'b0;
    #1 chk("rb_r_valid0", 64'(sbus.r_valid), 64'd1);
    chk("rb_r_last0", 64'(sbus.r_last), 64'd0);
    chk("rb_r_resp0", 64'(sbus.r_resp), 64'(RESP_SLVERR));
    chk("rb_r_data0", 64'(sbus.r_data), 64'd0);
    chk("rb_r_id0", 64'(sbus.r_id), 64'hD4);
    chk("rb_m_ar_valid", 64'(mbus.ar_valid), 64'd0);
    sbus.r_ready = 1'b1;
    step();
    #1 chk("rb_r_valid1", 64'(sbus.r_valid), 64'd1);
    chk("rb_r_last1", 64'(sbus.r_last), 64'd1);
    chk("rb_r_resp1", 64'(sbus.r_resp), 64'(RESP_SLVERR));
    chk("rb_r_data1", 64'(sbus.r_data), 64'd0);
    step();
    sbus.r_ready = 1'b0;
    #1 chk("rb_r_done", 64'(sbus.r_valid), 64'd0);
    chk("rb_ar_ready", 64'(sbus.ar_ready), 64'd1);

    // backpressure on both sides
    write_single(8'h77, 32'h0000_1800, 32'hA5A5_5A5A, 4'hC, RESP_OKAY, 5, 3);
    read_single(8'h78, 32'h0000_2800, 32'h1357_9BDF, RESP_OKAY, 2);

    // write and read issued in the same cycle
    fork
      write_single(8'h11, 32'h0000_5000, 32'h0F0F_0F0F, 4'h5, RESP_OKAY, 0, 1);
      read_single(8'h22, 32'h0000_6000, 32'hF00D_CAFE, RESP_EXOKAY, 0);
    join

    // reset while a read waits on the Lite AR handshake
    sbus.ar_id = 8'h44; sbus.ar_addr = 32'h0000_7000; sbus.ar_len = 8'd0; sbus.ar_valid = 1'b1;
    step();
    sbus.ar_valid = 1'b0;
    #1 chk("mr_ar_pending", 64'(mbus.ar_valid), 64'd1);
    rst = 1'b1;
    #1 chk("mr_m_ar_valid", 64'(mbus.ar_valid), 64'd0);
    chk("mr_s_ar_ready", 64'(sbus.ar_ready), 64'd0);
    chk("mr_s_aw_ready", 64'(sbus.aw_ready), 64'd0);
    chk("mr_s_r_valid", 64'(sbus.r_valid), 64'd0);
    chk("mr_m_r_ready", 64'(mbus.r_ready), 64'd0);
    step(); step();
    rst = 1'b0;
    #1 chk("mr_no_resp", 64'(sbus.r_valid), 64'd0);
    chk("mr_ar_idle", 64'(mbus.ar_valid), 64'd0);
    chk("mr_r_id_clr", 64'(sbus.r_id), 64'd0);
    step();
    read_single(8'h55, 32'h0000_4008, 32'h0BAD_F00D, RESP_OKAY, 0);
    write_single(8'h66, 32'h0000_400C, 32'h8765_4321, 4'hF, RESP_OKAY, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
